// File: rtl/bh1750_i2c_target.sv
// BH1750 ambient-light sensor emulator on an I2C target port.
// Accepts opcode writes, runs a timed one-time H-resolution measurement and
// returns the 16-bit result MSB-first on read. SCL is never stretched.
//
// Bus handshake: there is no valid/ready pair here. A received byte is
// presented on o_opcode together with a single-cycle o_opcode_valid pulse,
// which has no back-pressure; the decoder consumes it on that same cycle.
//
// Debug: o_state exposes the protocol FSM with a fixed encoding
// 0 IDLE, 1 ADDR, 2 ADDR_ACK, 3 WR_BYTE, 4 WR_ACK, 5 RD_BYTE, 6 RD_ACK, 7 IGNORE.
module bh1750_i2c_target #(
   parameter logic [6:0]  P_ADDR        = 7'h23,
   parameter int unsigned P_MEAS_CYCLES = 3_000_000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_scl,
   inout  wire         io_sda,
   input  logic [15:0] i_lux,
   output logic [7:0]  o_opcode,
   output logic        o_opcode_valid,
   output logic        o_powered,
   output logic        o_meas_busy,
   output logic [15:0] o_data,
   output logic [2:0]  o_state
);

   localparam int unsigned CW = (P_MEAS_CYCLES > 1) ? $clog2(P_MEAS_CYCLES) : 1;
   localparam logic [CW-1:0] MEAS_LOAD = CW'(P_MEAS_CYCLES - 1);

   localparam logic [7:0] OP_POWER_DOWN = 8'h00;
   localparam logic [7:0] OP_POWER_ON   = 8'h01;
   localparam logic [7:0] OP_RESET      = 8'h07;
   localparam logic [7:0] OP_ONE_TIME_H = 8'h20;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ADDR     = 3'd1,
      ST_ADDR_ACK = 3'd2,
      ST_WR_BYTE  = 3'd3,
      ST_WR_ACK   = 3'd4,
      ST_RD_BYTE  = 3'd5,
      ST_RD_ACK   = 3'd6,
      ST_IGNORE   = 3'd7
   } state_t;

   state_t        state;
   logic [2:0]    scl_s;     // [1] synchronized level, [2] previous level
   logic [2:0]    sda_s;
   logic          scl_rise;
   logic          scl_fall;
   logic          bus_start;
   logic          bus_stop;
   logic [3:0]    bit_cnt;
   logic [7:0]    shift_in;
   logic          rw;
   logic [7:0]    tx_shift;
   logic [15:0]   shadow;    // result snapshot for the read in progress
   logic          byte_idx;  // 0 while the MSB byte is being sent
   logic          rd_nack;
   logic [7:0]    next_rd_byte;
   logic          sda_oe;
   logic [CW-1:0] meas_cnt;
   logic          pd_now;

   // Open-drain: pull low or float; the async reset clears sda_oe at once.
   assign io_sda  = sda_oe ? 1'b0 : 1'bz;
   assign o_state = state;

   // Two-flop synchronizers plus one history flop for edge detection.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         scl_s <= 3'b111;
         sda_s <= 3'b111;
      end else begin
         scl_s <= {scl_s[1:0], i_scl};
         sda_s <= {sda_s[1:0], io_sda};
      end
   end

   // Bus edges and START/STOP conditions from the synchronized lines.
   always_comb begin
      scl_rise     = scl_s[1] & ~scl_s[2];
      scl_fall     = ~scl_s[1] & scl_s[2];
      bus_start    = scl_s[1] & scl_s[2] & sda_s[2] & ~sda_s[1];
      bus_stop     = scl_s[1] & scl_s[2] & ~sda_s[2] & sda_s[1];
      next_rd_byte = byte_idx ? 8'hFF : shadow[7:0];
   end

   // Protocol FSM: samples SDA on SCL rise, changes its drive on SCL fall.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state          <= ST_IDLE;
         bit_cnt        <= 4'd0;
         shift_in       <= 8'h00;
         rw             <= 1'b0;
         tx_shift       <= 8'h00;
         shadow         <= 16'h0000;
         byte_idx       <= 1'b0;
         rd_nack        <= 1'b0;
         sda_oe         <= 1'b0;
         o_opcode       <= 8'h00;
         o_opcode_valid <= 1'b0;
      end else begin
         o_opcode_valid <= 1'b0;
         if (bus_start) begin
            state   <= ST_ADDR;
            bit_cnt <= 4'd0;
            sda_oe  <= 1'b0;
         end else if (bus_stop) begin
            state   <= ST_IDLE;
            bit_cnt <= 4'd0;
            sda_oe  <= 1'b0;
         end else begin
            case (state)
               ST_ADDR: begin
                  if (scl_rise) begin
                     shift_in <= {shift_in[6:0], sda_s[1]};
                     if (bit_cnt == 4'd7) begin
                        bit_cnt <= 4'd0;
                        rw      <= sda_s[1];
                        state   <= (shift_in[6:0] == P_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                     end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end
               end
               ST_ADDR_ACK: begin
                  // First fall starts the ACK, second fall ends the 9th clock.
                  if (scl_fall) begin
                     if (bit_cnt == 4'd0) begin
                        sda_oe  <= 1'b1;
                        bit_cnt <= 4'd1;
                     end else begin
                        bit_cnt <= 4'd0;
                        if (rw) begin
                           state    <= ST_RD_BYTE;
                           shadow   <= o_data;
                           tx_shift <= o_data[15:8];
                           byte_idx <= 1'b0;
                           sda_oe   <= ~o_data[15];
                        end else begin
                           state  <= ST_WR_BYTE;
                           sda_oe <= 1'b0;
                        end
                     end
                  end
               end
               ST_WR_BYTE: begin
                  if (scl_rise) begin
                     shift_in <= {shift_in[6:0], sda_s[1]};
                     if (bit_cnt == 4'd7) begin
                        o_opcode       <= {shift_in[6:0], sda_s[1]};
                        o_opcode_valid <= 1'b1;
                        bit_cnt        <= 4'd0;
                        state          <= ST_WR_ACK;
                     end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end
               end
               ST_WR_ACK: begin
                  if (scl_fall) begin
                     if (bit_cnt == 4'd0) begin
                        sda_oe  <= 1'b1;
                        bit_cnt <= 4'd1;
                     end else begin
                        sda_oe  <= 1'b0;
                        bit_cnt <= 4'd0;
                        state   <= ST_WR_BYTE;
                     end
                  end
               end
               ST_RD_BYTE: begin
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall) begin
                     if (bit_cnt == 4'd8) begin
                        sda_oe  <= 1'b0;
                        bit_cnt <= 4'd0;
                        state   <= ST_RD_ACK;
                     end else begin
                        tx_shift <= {tx_shift[6:0], 1'b0};
                        sda_oe   <= ~tx_shift[6];
                     end
                  end
               end
               ST_RD_ACK: begin
                  if (scl_rise) begin
                     rd_nack <= sda_s[1];
                     bit_cnt <= 4'd1;
                  end else if (scl_fall && (bit_cnt == 4'd1)) begin
                     bit_cnt <= 4'd0;
                     if (rd_nack) begin
                        state  <= ST_IGNORE;
                        sda_oe <= 1'b0;
                     end else begin
                        state    <= ST_RD_BYTE;
                        tx_shift <= next_rd_byte;
                        sda_oe   <= ~next_rd_byte[7];
                        byte_idx <= 1'b1;
                     end
                  end
               end
               default: begin
                  // IDLE and IGNORE stay silent until the next START/STOP.
                  sda_oe <= 1'b0;
               end
            endcase
         end
      end
   end

   // A POWER_DOWN decoded on the completion cycle keeps the old result.
   always_comb begin
      pd_now = o_opcode_valid && (o_opcode == OP_POWER_DOWN);
   end

   // Opcode decode and one-time measurement countdown.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_powered   <= 1'b0;
         o_meas_busy <= 1'b0;
         o_data      <= 16'h0000;
         meas_cnt    <= '0;
      end else begin
         if (o_meas_busy) begin
            if (meas_cnt == '0) begin
               o_meas_busy <= 1'b0;
               o_powered   <= 1'b0;
               if (!pd_now) begin
                  o_data <= i_lux;
               end
            end else begin
               meas_cnt <= meas_cnt - CW'(1);
            end
         end
         if (o_opcode_valid) begin
            case (o_opcode)
               OP_POWER_DOWN: begin
                  o_powered   <= 1'b0;
                  o_meas_busy <= 1'b0;
                  meas_cnt    <= '0;
               end
               OP_POWER_ON: begin
                  o_powered <= 1'b1;
               end
               OP_RESET: begin
                  if (o_powered) begin
                     o_data <= 16'h0000;
                  end
               end
               OP_ONE_TIME_H: begin
                  if (o_powered) begin
                     o_meas_busy <= 1'b1;
                     meas_cnt    <= MEAS_LOAD;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bh1750_i2c_target.sv
// Bench for bh1750_i2c_target: bit-banged I2C master, table of opcode
// vectors, hand-written multi-cycle sequences and a randomized run checked
// against a transaction-level sensor model.
module tb_bh1750_i2c_target;

   localparam logic [6:0] ADDR  = 7'h23;
   localparam int         MEAS  = 100;
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RD_BYTE = 3'd5;
   localparam logic [2:0] S_IGNORE  = 3'd7;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        scl = 1'b1;
   logic        m_low = 1'b0;
   logic [15:0] lux = 16'hA5C3;
   logic [7:0]  opcode;
   logic        opcode_valid;
   logic        powered;
   logic        meas_busy;
   logic [15:0] data;
   logic [2:0]  state;
   wire         sda_bus;

   assign sda_bus = m_low ? 1'b0 : 1'bz;
   pullup (sda_bus);

   bh1750_i2c_target #(.P_ADDR(ADDR), .P_MEAS_CYCLES(MEAS)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_scl          (scl),
      .io_sda         (sda_bus),
      .i_lux          (lux),
      .o_opcode       (opcode),
      .o_opcode_valid (opcode_valid),
      .o_powered      (powered),
      .o_meas_busy    (meas_busy),
      .o_data         (data),
      .o_state        (state)
   );

   // clock / reset
   always #5 clk = ~clk;

   // event counters sampled away from the active edge
   int pulse_total = 0;
   int busy_total  = 0;
   always @(negedge clk) begin
      if (opcode_valid) pulse_total <= pulse_total + 1;
      if (meas_busy)    busy_total  <= busy_total + 1;
   end

   int checks = 0;
   int errors = 0;
   int q = 4;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic wait_q();
      repeat (q) @(negedge clk);
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      m_low = 1'b0; wait_q();
      scl = 1'b1;   wait_q();
      m_low = 1'b1; wait_q();
      scl = 1'b0;   wait_q();
   endtask

   task automatic i2c_stop();
      m_low = 1'b1; wait_q();
      scl = 1'b1;   wait_q();
      m_low = 1'b0; wait_q();
   endtask

   task automatic wbit(input logic b);
      m_low = ~b;   wait_q();
      scl = 1'b1;   wait_q(); wait_q();
      scl = 1'b0;   wait_q();
   endtask

   task automatic rbit(output logic b);
      m_low = 1'b0; wait_q();
      scl = 1'b1;   wait_q();
      b = sda_bus;  wait_q();
      scl = 1'b0;   wait_q();
   endtask

   task automatic wbyte(input logic [7:0] v, output logic ack);
      for (int i = 7; i >= 0; i--) wbit(v[i]);
      rbit(ack);
   endtask

   task automatic rbyte(output logic [7:0] v, input logic nack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         rbit(b);
         v[i] = b;
      end
      wbit(nack);
   endtask

   task automatic i2c_write(input logic [7:0] op, output logic [1:0] acks);
      logic a0, a1;
      i2c_start();
      wbyte({ADDR, 1'b0}, a0);
      wbyte(op, a1);
      i2c_stop();
      acks = {a0, a1};
   endtask

   task automatic i2c_read2(output logic [15:0] v, output logic ack);
      logic [7:0] hi, lo;
      i2c_start();
      wbyte({ADDR, 1'b1}, ack);
      rbyte(hi, 1'b0);
      rbyte(lo, 1'b1);
      i2c_stop();
      v = {hi, lo};
   endtask

   typedef struct {
      logic [7:0]  op;
      int          wait_cyc;
      logic        exp_pw;
      logic        exp_busy;
      logic [15:0] exp_data;
   } vec_t;

   vec_t tbl [9];

   initial begin
      logic [1:0]  acks;
      logic        ack, a0, a1, a2;
      logic [7:0]  b0, b1, b2;
      logic [15:0] rd;
      int          p0, bz0;
      logic        m_pw;
      logic [15:0] m_data;
      logic [7:0]  op;

      // table: expected sensor state after each opcode write (lux 16'h1234)
      tbl[0] = '{8'h00,   0, 1'b0, 1'b0, 16'hA5C3};
      tbl[1] = '{8'h07,   0, 1'b0, 1'b0, 16'hA5C3};
      tbl[2] = '{8'h20, 200, 1'b0, 1'b0, 16'hA5C3};
      tbl[3] = '{8'h01,   0, 1'b1, 1'b0, 16'hA5C3};
      tbl[4] = '{8'h07,   0, 1'b1, 1'b0, 16'h0000};
      tbl[5] = '{8'h20,   0, 1'b1, 1'b1, 16'h0000};
      tbl[6] = '{8'h55, 200, 1'b0, 1'b0, 16'h1234};
      tbl[7] = '{8'h01,   0, 1'b1, 1'b0, 16'h1234};
      tbl[8] = '{8'hA5,   0, 1'b1, 1'b0, 16'h1234};

      // reset state
      wait_clk(5);
      check("rst_sda",     sda_bus,   1'b1);
      check("rst_opcode",  opcode,    8'h00);
      check("rst_valid",   opcode_valid, 1'b0);
      check("rst_powered", powered,   1'b0);
      check("rst_busy",    meas_busy, 1'b0);
      check("rst_data",    data,      16'h0000);
      check("rst_state",   state,     S_IDLE);
      rst = 1'b0;
      wait_clk(5);

      // foreign address 0x24: never ACKed, FSM ignores the bytes
      p0 = pulse_total;
      i2c_start();
      wbyte(8'h48, a0);
      wbyte(8'h01, a1);
      check("foreign_addr_nack", a0, 1'b1);
      check("foreign_data_nack", a1, 1'b1);
      check("foreign_state",     state, S_IGNORE);
      i2c_stop();
      wait_clk(4);
      check("foreign_pulses", pulse_total - p0, 0);
      check("foreign_opcode", opcode, 8'h00);
      check("foreign_idle",   state, S_IDLE);

      // ONE_TIME_H while powered down does nothing
      bz0 = busy_total;
      i2c_write(8'h20, acks);
      check("pd_meas_acks", acks, 2'b00);
      check("pd_meas_busy", meas_busy, 1'b0);
      wait_clk(200);
      i2c_read2(rd, ack);
      check("pd_meas_read",  rd, 16'h0000);
      check("pd_meas_nbusy", busy_total - bz0, 0);

      // write 0x46, 0x01
      p0 = pulse_total;
      i2c_write(8'h01, acks);
      wait_clk(4);
      check("pon_acks",    acks, 2'b00);
      check("pon_opcode",  opcode, 8'h01);
      check("pon_pulses",  pulse_total - p0, 1);
      check("pon_powered", powered, 1'b1);

      // full master sequence 00/01/07/20, wait, read
      i2c_write(8'h00, acks); check("seq_ack00", acks, 2'b00);
      i2c_write(8'h01, acks); check("seq_ack01", acks, 2'b00);
      i2c_write(8'h07, acks); check("seq_ack07", acks, 2'b00);
      bz0 = busy_total;
      i2c_write(8'h20, acks); check("seq_ack20", acks, 2'b00);
      wait_clk(200);
      check("seq_busy_len", busy_total - bz0, MEAS);
      check("seq_powered",  powered, 1'b0);
      check("seq_data",     data, 16'hA5C3);
      i2c_read2(rd, ack);
      check("seq_read_ack", ack, 1'b0);
      check("seq_read",     rd, 16'hA5C3);

      // 3-byte read with ACK, ACK, NACK
      i2c_start();
      wbyte({ADDR, 1'b1}, ack);
      rbyte(b0, 1'b0);
      rbyte(b1, 1'b0);
      rbyte(b2, 1'b1);
      m_low = 1'b0;
      wait_clk(4);
      check("rd3_b0",    b0, 8'hA5);
      check("rd3_b1",    b1, 8'hC3);
      check("rd3_b2",    b2, 8'hFF);
      check("rd3_sda",   sda_bus, 1'b1);
      check("rd3_state", state, S_IGNORE);
      i2c_stop();
      wait_clk(4);
      check("rd3_idle", state, S_IDLE);

      // table-driven opcode vectors
      lux = 16'h1234;
      for (int i = 0; i < 9; i++) begin
         p0 = pulse_total;
         i2c_write(tbl[i].op, acks);
         wait_clk(tbl[i].wait_cyc + 2);
         check($sformatf("tbl%0d_acks", i),    acks, 2'b00);
         check($sformatf("tbl%0d_pulse", i),   pulse_total - p0, 1);
         check($sformatf("tbl%0d_opcode", i),  opcode, tbl[i].op);
         check($sformatf("tbl%0d_powered", i), powered, tbl[i].exp_pw);
         check($sformatf("tbl%0d_busy", i),    meas_busy, tbl[i].exp_busy);
         check($sformatf("tbl%0d_data", i),    data, tbl[i].exp_data);
      end

      // fast SCL: back-to-back bytes inside one write transaction
      q = 2;
      lux = 16'h0F0F;
      // ONE_TIME_H twice: restart gives 9 bit-times (8 clk each) + full count
      bz0 = busy_total;
      i2c_start();
      wbyte({ADDR, 1'b0}, a0);
      wbyte(8'h20, a1);
      wbyte(8'h20, a2);
      i2c_stop();
      wait_clk(200);
      check("restart_acks", {a0, a1, a2}, 3'b000);
      check("restart_len",  busy_total - bz0, 9 * 8 + MEAS);
      check("restart_data", data, 16'h0F0F);
      // POWER_DOWN during a measurement aborts it
      lux = 16'h7777;
      i2c_write(8'h01, acks);
      bz0 = busy_total;
      i2c_start();
      wbyte({ADDR, 1'b0}, a0);
      wbyte(8'h20, a1);
      wbyte(8'h00, a2);
      i2c_stop();
      wait_clk(200);
      check("abort_acks",    {a0, a1, a2}, 3'b000);
      check("abort_len",     busy_total - bz0, 9 * 8);
      check("abort_powered", powered, 1'b0);
      check("abort_data",    data, 16'h0F0F);
      q = 4;

      // randomized opcodes against a transaction-level sensor model
      m_pw = powered;
      m_data = data;
      for (int it = 0; it < 16; it++) begin
         case ($urandom_range(0, 4))
            0: op = 8'h00;
            1: op = 8'h01;
            2: op = 8'h07;
            3: op = 8'h20;
            default: op = 8'h10 | 8'($urandom_range(0, 15));
         endcase
         lux = 16'($urandom);
         i2c_write(op, acks);
         wait_clk(200);
         if (op == 8'h00) m_pw = 1'b0;
         else if (op == 8'h01) m_pw = 1'b1;
         else if (op == 8'h07 && m_pw) m_data = 16'h0000;
         else if (op == 8'h20 && m_pw) begin
            m_data = lux;
            m_pw = 1'b0;
         end
         check($sformatf("rnd%0d_acks", it),    acks, 2'b00);
         check($sformatf("rnd%0d_powered", it), powered, m_pw);
         check($sformatf("rnd%0d_busy", it),    meas_busy, 1'b0);
         check($sformatf("rnd%0d_data", it),    data, m_data);
         if (it % 4 == 3) begin
            i2c_read2(rd, ack);
            check($sformatf("rnd%0d_read", it), rd, m_data);
         end
      end

      // reset asserted while the target drives a 0 data bit
      lux = 16'hA5C3;
      i2c_write(8'h01, acks);
      i2c_write(8'h20, acks);
      wait_clk(200);
      i2c_start();
      wbyte({ADDR, 1'b1}, ack);
      rbit(a0);
      check("rrst_bit7",  a0, 1'b1);
      check("rrst_drive", sda_bus, 1'b0);
      check("rrst_state", state, S_RD_BYTE);
      rst = 1'b1;
      #1;
      check("rrst_sda_z",   sda_bus, 1'b1);
      check("rrst_opcode",  opcode, 8'h00);
      check("rrst_powered", powered, 1'b0);
      check("rrst_busy",    meas_busy, 1'b0);
      check("rrst_data",    data, 16'h0000);
      check("rrst_idle",    state, S_IDLE);
      @(negedge clk);
      rst = 1'b0;
      wait_clk(4);
      i2c_stop();
      i2c_write(8'h01, acks);
      wait_clk(4);
      check("post_rst_acks",    acks, 2'b00);
      check("post_rst_opcode",  opcode, 8'h01);
      check("post_rst_powered", powered, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bh1750_i2c_target.md
Name: bh1750_i2c_target

Overview:
- Behavioural-synthesizable I2C target (slave) that emulates a BH1750 ambient-light sensor.
- Answers the BH1750 master controller on the same bus: accepts opcode writes, runs a timed one-time H-resolution measurement, and returns a 16-bit result MSB-first on read.
- Used for on-board loopback tests and simulation benches where no physical sensor is fitted. Lux value comes from an input port.

Parameters:
P_ADDR, 7'h23, 7-bit target address (ADDR pin low).
P_MEAS_CYCLES, 3_000_000, i_clk cycles from accepted ONE_TIME_H to result latched (120 ms at 25 MHz).

Ports:
i_clk  input  1  system clock; must be at least 8x SCL frequency.
i_rst  input  1  asynchronous, active-high reset.
i_scl  input  1  I2C SCL from bus; target never stretches the clock.
io_sda  inout  1  I2C SDA, open-drain: drives 0 or Z only.
i_lux  input  16  raw count sampled as the measurement result.
o_opcode  output  8  last opcode byte written by the master.
o_opcode_valid  output  1  one-cycle pulse when o_opcode updates.
o_powered  output  1  1 = powered on, 0 = power-down.
o_meas_busy  output  1  1 while a measurement countdown runs.
o_data  output  16  current result register (value served on read).

Behaviour:
- Reset (async, i_rst=1): SDA released (Z), o_opcode=0, o_opcode_valid=0, o_powered=0, o_meas_busy=0, o_data=16'h0000, FSM=IDLE, counters=0.
- Input conditioning: SCL and SDA each pass through a 2-FF synchronizer. Edge detects operate on the synchronized values.
- Bus conditions:
  - START = SDA falls while SCL is high.
  - STOP = SDA rises while SCL is high.
  - START in any state, including a repeated START, forces FSM to ADDR with bit count 0.
  - STOP in any state forces IDLE and releases SDA.
- Sampling and driving:
  - Target samples SDA on SCL rising edge.
  - Target changes its SDA drive only on SCL falling edge, registered by 1 cycle.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
  - ADDR: shift 8 bits MSB-first. If addr[7:1]==P_ADDR, go to ADDR_ACK. Otherwise go to IGNORE, stay silent until START or STOP.
  - ADDR_ACK: drive SDA=0 for the 9th clock. Then enter WR_BYTE if R/W=0, or RD_BYTE if R/W=1.
  - WR_BYTE: shift 8 bits, then WR_ACK. WR_ACK drives ACK (0) for every byte. On the 8th-bit rising edge: o_opcode<=byte and o_opcode_valid pulses 1 cycle. Return to WR_BYTE for further bytes.
  - RD_BYTE: drive bits MSB-first. Byte 0 = o_data[15:8], byte 1 = o_data[7:0], bytes 2+ = 8'hFF. SDA is released during the 9th clock, then RD_ACK.
  - RD_ACK: sample master ACK. ACK (0) goes to RD_BYTE with the next byte. NACK (1) goes to IGNORE until STOP or START.
- Opcode decode (applied at o_opcode_valid):
  - 8'h00 POWER_DOWN: o_powered<=0. Aborts any measurement; o_meas_busy<=0 and counter cleared.
  - 8'h01 POWER_ON: o_powered<=1.
  - 8'h07 RESET: o_data<=0 only if o_powered=1. Ignored when powered down.
  - 8'h20 ONE_TIME_H: only if o_powered=1. Sets o_meas_busy=1 and loads the counter. A ONE_TIME_H received while busy restarts the counter.
  - Any other value: stored in o_opcode, no effect.
- Measurement completion:
  - Occurs P_MEAS_CYCLES cycles after o_opcode_valid.
  - o_data<=i_lux, sampled on that cycle.
  - o_meas_busy<=0 and o_powered<=0, since the one-time mode auto-powers down.
- Read during a measurement returns the previous o_data.
- If completion coincides with a read in progress, o_data updates but the byte already shifting is unaffected. The MSB/LSB of that transaction is latched at the ADDR_ACK to RD_BYTE transition into a 16-bit shadow register.
- Simultaneous POWER_DOWN opcode and completion on the same cycle: POWER_DOWN wins and o_data is unchanged.
- Reset mid-transaction releases SDA immediately (asynchronous). The master sees NACK or all-ones.

Test Plan:
Bench setup: bh1750 master drives the bus, P_MEAS_CYCLES=100, i_lux=16'hA5C3.
- Write 0x46 then 0x01 -> ACK on both bytes; o_opcode=8'h01, one o_opcode_valid pulse, o_powered=1.
- Full master sequence 00/01/07/20, 200 ms wait, read -> master receives 16'hA5C3. o_meas_busy high for exactly 100 cycles, then o_powered=0.
- Address byte 0x48 (addr 0x24) -> SDA never driven low; FSM in IGNORE; no opcode pulse.
- Send ONE_TIME_H while powered down -> o_meas_busy stays 0; a subsequent read returns 16'h0000.
- Read 3 bytes (ACK, ACK, NACK) after a measurement -> bytes A5, C3, FF; SDA released after the NACK; STOP returns FSM to IDLE.
- Assert i_rst during RD_BYTE with a 0 bit on the bus -> SDA goes Z in the same cycle; all outputs at their reset values; the next START/addressed write is ACKed normally.
